// File: rtl/seq_divider16.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged with the results.
module seq_divider16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] dvs_q, dvs_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    // The stored remainder always fits in 16 bits after a step; only the
    // shifted trial value needs the 17th bit for the compare.
    logic [16:0] rem_shift;
    logic [16:0] rem_diff;
    logic        take;

    always_comb begin
        rem_shift = {rem_q, quo_q[15]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        take      = rem_shift >= {1'b0, dvs_q};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor != 16'd0) begin
                        state_d = StRun;
                        count_d = 4'd0;
                        rem_d   = 16'd0;
                        quo_d   = dividend;
                        dvs_d   = divisor;
                    end else begin
                        state_d     = StDone;
                        quotient_d  = 16'hFFFF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            StRun: begin
                if (take) begin
                    rem_d = rem_diff[15:0];
                    quo_d = {quo_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_shift[15:0];
                    quo_d = {quo_q[14:0], 1'b0};
                end
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    state_d     = StDone;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= 4'd0;
            rem_q       <= 16'd0;
            quo_q       <= 16'd0;
            dvs_q       <= 16'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
    end

endmodule

// File: tb/tb_seq_divider16.sv
// Randomised and directed checks of seq_divider16 against an arithmetic model.
module tb_seq_divider16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total;
    int bad;

    seq_divider16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {quotient, remainder, div_by_zero}
    function automatic logic [32:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return {16'hFFFF, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    // Issue one division; optionally scramble inputs while it runs.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input bit noise);
        logic [32:0] exp;
        int edges;
        int busy_cnt;
        exp = ref_div(a, b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start    = 1'($urandom);
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check("done_latency", edges, (b == 16'd0) ? 1 : 17);
        check("busy_cycles", busy_cnt, (b == 16'd0) ? 0 : 16);
        check("busy_with_done", {31'd0, busy & done}, 0);
        check("quotient", {16'd0, quotient}, {16'd0, exp[32:17]});
        check("remainder", {16'd0, remainder}, {16'd0, exp[16:1]});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp[0]});
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 0);
        check("result_hold", {quotient, remainder}, exp[32:1]);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {quotient, remainder}, 0);
        check("reset_flags", {29'd0, busy, done, div_by_zero}, 0);
        rst_n = 1'b1;

        do_div(16'd100, 16'd7, 1'b0);
        do_div(16'hFFFF, 16'd1, 1'b0);
        do_div(16'd3, 16'd10, 1'b0);
        do_div(16'd5, 16'd0, 1'b0);
        do_div(16'd100, 16'd7, 1'b0);
        do_div(16'd1000, 16'd9, 1'b1);
        do_div(16'hFFFF, 16'hFFFF, 1'b0);
        do_div(16'h8000, 16'hFFFF, 1'b0);

        // Reset in the middle of a run discards it silently.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_run_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_reset_outputs", {quotient, remainder}, 0);
        check("mid_reset_flags", {29'd0, busy, done, div_by_zero}, 0);
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no_done_after_reset", seen, 0);
        end
        do_div(16'd60000, 16'd256, 1'b0);

        // Random operands, some with small or zero divisors, half with noise.
        for (int i = 0; i < 30; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            do_div(a, b, 1'($urandom));
        end

        // Start held high: results every 17 cycles.
        begin
            int pulses;
            int last;
            @(negedge clk);
            start    = 1'b1;
            dividend = 16'd12345;
            divisor  = 16'd123;
            pulses   = 0;
            last     = -1;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                check("b2b_busy_done", {31'd0, busy & done}, 0);
                if (done) begin
                    check("b2b_result", {quotient, remainder}, {16'd100, 16'd45});
                    if (last >= 0) check("b2b_period", c - last, 17);
                    else check("b2b_first", c, 17);
                    last = c;
                    pulses++;
                end
            end
            start = 1'b0;
            check("b2b_pulses", pulses, 3);
            repeat (20) @(negedge clk);
            check("b2b_idle", {30'd0, busy, done}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider16.md
# seq_divider16

Sequential 16-bit unsigned restoring divider. It computes quotient and remainder one bit per clock under a start/busy/done handshake. It is the inverse-operation companion to the ALU's 16-bit multiplier, sits beside it on the same operand buses, and returns results that reconstruct the dividend: quotient*divisor + remainder = dividend.

## Interface
Parameters:
- none; width fixed at 16 bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  request a division; sampled only in IDLE or DONE
- dividend  input  16  unsigned dividend, latched on accepting edge
- divisor  input  16  unsigned divisor, latched on accepting edge
- quotient  output  16  result quotient; held until next accepted start
- remainder  output  16  result remainder; held until next accepted start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse, results valid
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. When start=1 and divisor≠0, latch operands and go to RUN with count=0. When start=1 and divisor=0, go to DONE with quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
- RUN: one restoring step per edge.
  - Shift the 17-bit partial remainder R left, bringing in the MSB of the working dividend/quotient register Q; Q shifts left.
  - If R ≥ divisor: R -= divisor and Q[0]=1. Otherwise Q[0]=0.
  - count increments. After the 16th step (count 15→wrap), go to DONE.
- DONE: done=1 for exactly one cycle. quotient=Q and remainder=R[15:0]; div_by_zero=0 for a normal division.
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations. Otherwise go to IDLE.
- start during RUN is ignored. dividend and divisor changes during RUN are ignored because operands are latched.
- Output registers (quotient, remainder, div_by_zero) update only on entry to DONE. They hold through IDLE and through the next RUN until the next DONE.
- R is 17 bits so the compare never overflows. The subtract result always fits in 16 bits.
- Reset (rst_n=0 at an edge), in any state including mid-RUN:
  - state=IDLE, count=0.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Any in-flight operation is discarded with no done pulse.

## Timing
- Edge E0 samples start=1 (non-zero divisor). busy=1 from after E0 through after E15.
- Edges E1..E16 perform the 16 steps.
- After E16: busy=0, done=1, results valid. Latency is 16 edges from the accepting edge.
- Next op: start=1 at E17 (state DONE) is accepted, giving a 17-cycle throughput per division.
- Divide-by-zero: after E0, done=1 and div_by_zero=1, and busy never asserts. Latency is 1 edge.
- done and busy are never high simultaneously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then dividend=100, divisor=7, start pulse → busy for 16 cycles, then done with quotient=14, remainder=2, div_by_zero=0.
- dividend=16'hFFFF, divisor=1 → quotient=16'hFFFF, remainder=0. Then dividend=3, divisor=10 → quotient=0, remainder=3.
- dividend=5, divisor=0 → done one cycle after start, quotient=16'hFFFF, remainder=5, div_by_zero=1, busy stays 0. The next valid division clears div_by_zero.
- Start 1000/9, then pulse start with 50/5 and change operands at cycles 3 and 8 of RUN → result still quotient=111, remainder=1; the extra start is ignored.
- Start 1000/9, drive rst_n=0 at cycle 8 of RUN → all outputs 0 after that edge and no done pulse. A new 60000/256 then gives quotient=234, remainder=96.
- Hold start=1 continuously with 12345/123 → done pulses every 17 cycles, each with quotient=100, remainder=45.
